pipeline_cfg_master: RTL and testbench

Command initiator for the DSP pipeline's configuration port. Consumes a byte stream from the host link (SPI/UART byte front-end) and decodes framed commands. Drives the instruction-write, register-write/update, delay-allocation, commit and full-reset strobes with their ack handshakes. Sits between the host byte receiver and dsp_pipeline.

---
 rtl/pipeline_cfg_master.sv | 262 ++++++++++++++++++++++++++
 tb/tb_pipeline_cfg_master.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_cfg_master.sv
// pipeline_cfg_master
// Command initiator for the DSP pipeline configuration port. Decodes framed
// host commands (opcode byte + MSB-first payload) and drives the instruction
// write, register write/update, delay allocation, commit and full-reset
// strobes with their ack handshakes.
// Optional build macro: CFG_TIMEOUT_EN adds an ack/reset timeout counter.

module pipeline_cfg_master #(
  parameter int data_width     = 16,
  parameter int n_blocks       = 256,
  parameter int reg_addr_width = 4,
  parameter int instr_width    = 32,
  parameter int timeout_cycles = 4096
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [7:0]                                    in_byte,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  output logic [$clog2(n_blocks)-1:0]                   block_target,
  output logic [$clog2(n_blocks)+reg_addr_width-1:0]    reg_target,
  output logic [instr_width-1:0]                        instr_val,
  output logic                                          instr_write,
  input  logic                                          instr_write_ack,
  output logic [data_width-1:0]                         ctrl_data,
  output logic                                          reg_write,
  output logic                                          reg_update,
  input  logic                                          reg_write_ack,
  output logic [2*data_width-1:0]                       delay_size,
  output logic [2*data_width-1:0]                       init_delay,
  output logic                                          alloc_delay,
  output logic                                          reg_writes_commit,
  output logic                                          full_reset,
  input  logic                                          resetting,
  output logic                                          busy,
  output logic                                          error,
  output logic [15:0]                                   cmds_done
);

  localparam int BW          = $clog2(n_blocks);
  localparam int RW          = reg_addr_width;
  localparam int INSTR_BYTES = instr_width / 8;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_PAYLOAD    = 3'd1;
  localparam logic [2:0] ST_ISSUE      = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK   = 3'd3;
  localparam logic [2:0] ST_WAIT_RESET = 3'd4;

  localparam logic [7:0] OP_WRITE_INSTR = 8'h01;
  localparam logic [7:0] OP_WRITE_REG   = 8'h02;
  localparam logic [7:0] OP_UPDATE_REG  = 8'h03;
  localparam logic [7:0] OP_ALLOC_DELAY = 8'h04;
  localparam logic [7:0] OP_COMMIT      = 8'h05;
  localparam logic [7:0] OP_FULL_RESET  = 8'h06;

  logic [2:0] state;
  logic [7:0] opcode;
  logic [7:0] byte_idx;
  logic [7:0] last_idx;
  logic       rst_seen;
  logic       rst_wait;

  logic       accept;
  logic       op_known;
  logic [7:0] op_len;
  logic       ack_sel;
  logic       timed_out;

  // Handshake and status flags derived directly from the current state
  always_comb begin
    in_ready = (state == ST_IDLE) || (state == ST_PAYLOAD);
    busy     = (state != ST_IDLE);
    accept   = in_valid && in_ready;
    ack_sel  = (opcode == OP_WRITE_INSTR) ? instr_write_ack : reg_write_ack;
  end

  // Opcode decode: whether the byte is a known command and its payload length
  always_comb begin
    op_known = 1'b1;
    op_len   = 8'd0;
    case (in_byte)
      OP_WRITE_INSTR:              op_len = 8'(1 + INSTR_BYTES);
      OP_WRITE_REG, OP_UPDATE_REG: op_len = 8'd4;
      OP_ALLOC_DELAY:              op_len = 8'd8;
      OP_COMMIT, OP_FULL_RESET:    op_len = 8'd0;
      default:                     op_known = 1'b0;
    endcase
  end

`ifdef CFG_TIMEOUT_EN
  localparam int TW = $clog2(timeout_cycles + 1);
  logic [TW-1:0] wait_cnt;

  // Cycle counter for the two waiting states; restarts on every entry
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if ((state == ST_WAIT_ACK) || (state == ST_WAIT_RESET)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign timed_out = ((state == ST_WAIT_ACK) || (state == ST_WAIT_RESET)) &&
                     (wait_cnt == TW'(timeout_cycles - 1));
`else
  assign timed_out = 1'b0;
`endif

  // Command sequencer: frame tracking, strobe issue, ack/reset waits, counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      opcode            <= 8'd0;
      byte_idx          <= 8'd0;
      last_idx          <= 8'd0;
      rst_seen          <= 1'b0;
      rst_wait          <= 1'b0;
      instr_write       <= 1'b0;
      reg_write         <= 1'b0;
      reg_update        <= 1'b0;
      alloc_delay       <= 1'b0;
      reg_writes_commit <= 1'b0;
      full_reset        <= 1'b0;
      error             <= 1'b0;
      cmds_done         <= 16'd0;
    end else begin
      alloc_delay       <= 1'b0;
      reg_writes_commit <= 1'b0;
      full_reset        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (op_known) begin
              opcode   <= in_byte;
              byte_idx <= 8'd0;
              last_idx <= op_len - 8'd1;
              state    <= (op_len == 8'd0) ? ST_ISSUE : ST_PAYLOAD;
            end else begin
              error <= 1'b1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (accept) begin
            byte_idx <= byte_idx + 8'd1;
            if (byte_idx == last_idx) begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          case (opcode)
            OP_WRITE_INSTR: begin
              instr_write <= 1'b1;
              state       <= ST_WAIT_ACK;
            end
            OP_WRITE_REG: begin
              reg_write <= 1'b1;
              state     <= ST_WAIT_ACK;
            end
            OP_UPDATE_REG: begin
              reg_update <= 1'b1;
              state      <= ST_WAIT_ACK;
            end
            OP_ALLOC_DELAY: begin
              alloc_delay <= 1'b1;
              cmds_done   <= cmds_done + 16'd1;
              state       <= ST_IDLE;
            end
            OP_COMMIT: begin
              reg_writes_commit <= 1'b1;
              cmds_done         <= cmds_done + 16'd1;
              state             <= ST_IDLE;
            end
            OP_FULL_RESET: begin
              full_reset <= 1'b1;
              rst_seen   <= 1'b0;
              rst_wait   <= 1'b0;
              state      <= ST_WAIT_RESET;
            end
            default: state <= ST_IDLE;
          endcase
        end
        ST_WAIT_ACK: begin
          if (ack_sel) begin
            instr_write <= 1'b0;
            reg_write   <= 1'b0;
            reg_update  <= 1'b0;
            cmds_done   <= cmds_done + 16'd1;
            state       <= ST_IDLE;
          end else if (timed_out) begin
            instr_write <= 1'b0;
            reg_write   <= 1'b0;
            reg_update  <= 1'b0;
            error       <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_WAIT_RESET: begin
          if (timed_out) begin
            error <= 1'b1;
            state <= ST_IDLE;
          end else if (resetting) begin
            rst_seen <= 1'b1;
          end else if (rst_seen) begin
            cmds_done <= cmds_done + 16'd1;
            state     <= ST_IDLE;
          end else if (rst_wait) begin
            error <= 1'b1;
            state <= ST_IDLE;
          end else begin
            rst_wait <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Payload capture: data outputs change only while bytes are being received
  always_ff @(posedge clk) begin
    if (reset) begin
      block_target <= '0;
      reg_target   <= '0;
      instr_val    <= '0;
      ctrl_data    <= '0;
      delay_size   <= '0;
      init_delay   <= '0;
    end else if ((state == ST_PAYLOAD) && accept) begin
      case (opcode)
        OP_WRITE_INSTR: begin
          if (byte_idx == 8'd0) begin
            block_target <= BW'(in_byte);
          end else begin
            instr_val <= {instr_val[instr_width-9:0], in_byte};
          end
        end
        OP_WRITE_REG, OP_UPDATE_REG: begin
          if (byte_idx == 8'd0) begin
            block_target <= BW'(in_byte);
          end else if (byte_idx == 8'd1) begin
            reg_target <= {block_target, in_byte[RW-1:0]};
          end else begin
            ctrl_data <= {ctrl_data[data_width-9:0], in_byte};
          end
        end
        OP_ALLOC_DELAY: begin
          if (byte_idx < 8'd4) begin
            delay_size <= {delay_size[2*data_width-9:0], in_byte};
          end else begin
            init_delay <= {init_delay[2*data_width-9:0], in_byte};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_cfg_master.sv
// tb_pipeline_cfg_master
// Directed test-plan frames followed by randomized command frames, each
// checked against a byte-level reference model of the command protocol.

module tb_pipeline_cfg_master;

  logic        clk;
  logic        reset;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  block_target;
  logic [11:0] reg_target;
  logic [31:0] instr_val;
  logic        instr_write;
  logic        instr_write_ack;
  logic [15:0] ctrl_data;
  logic        reg_write;
  logic        reg_update;
  logic        reg_write_ack;
  logic [31:0] delay_size;
  logic [31:0] init_delay;
  logic        alloc_delay;
  logic        reg_writes_commit;
  logic        full_reset;
  logic        resetting;
  logic        busy;
  logic        error;
  logic [15:0] cmds_done;

  int checks;
  int failures;

  // reference model state
  logic [7:0]  exp_block;
  logic [11:0] exp_regt;
  logic [31:0] exp_instr;
  logic [15:0] exp_ctrl;
  logic [31:0] exp_size;
  logic [31:0] exp_init;
  logic [15:0] exp_cmds;
  logic        exp_error;
  logic [7:0]  payload[$];

  pipeline_cfg_master #(
    .data_width(16), .n_blocks(256), .reg_addr_width(4),
    .instr_width(32), .timeout_cycles(16)
  ) dut (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .block_target(block_target), .reg_target(reg_target),
    .instr_val(instr_val), .instr_write(instr_write),
    .instr_write_ack(instr_write_ack), .ctrl_data(ctrl_data),
    .reg_write(reg_write), .reg_update(reg_update),
    .reg_write_ack(reg_write_ack), .delay_size(delay_size),
    .init_delay(init_delay), .alloc_delay(alloc_delay),
    .reg_writes_commit(reg_writes_commit), .full_reset(full_reset),
    .resetting(resetting), .busy(busy), .error(error), .cmds_done(cmds_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // present one byte (after an optional idle stall) and wait for acceptance
  task automatic applyStimulus(input logic [7:0] b, input int stall);
    int g;
    in_valid = 1'b0;
    repeat (stall) @(negedge clk);
    in_byte  = b;
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    checkOutput("in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic logic strobeOf(input int sel);
    case (sel)
      0:       return instr_write;
      1:       return reg_write;
      default: return reg_update;
    endcase
  endfunction

  function automatic logic pulseOf(input int sel);
    return (sel == 0) ? alloc_delay : reg_writes_commit;
  endfunction

  // wait for a held strobe, ack it after 'delay' extra cycles, return its width
  task automatic serviceAck(input int sel, input int delay, output int hi);
    int g;
    g = 0;
    while (!strobeOf(sel) && g < 10) begin
      @(negedge clk);
      g++;
    end
    checkOutput("strobe_rise", strobeOf(sel), 1);
    hi = 0;
    while (strobeOf(sel) && hi < 100) begin
      hi++;
      if (sel == 0) instr_write_ack = (hi == delay + 1);
      else          reg_write_ack   = (hi == delay + 1);
      @(negedge clk);
    end
    instr_write_ack = 1'b0;
    reg_write_ack   = 1'b0;
  endtask

  // count cycles a one-shot pulse is high over a short window
  task automatic watchPulse(input int sel, output int hi);
    hi = 0;
    repeat (4) begin
      if (pulseOf(sel)) hi++;
      @(negedge clk);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ":busy"}, busy, 0);
    checkOutput({tag, ":in_ready"}, in_ready, 1);
    checkOutput({tag, ":error"}, error, exp_error);
    checkOutput({tag, ":cmds_done"}, cmds_done, exp_cmds);
    checkOutput({tag, ":block"}, block_target, exp_block);
    checkOutput({tag, ":reg_target"}, reg_target, exp_regt);
    checkOutput({tag, ":instr_val"}, instr_val, exp_instr);
    checkOutput({tag, ":ctrl_data"}, ctrl_data, exp_ctrl);
    checkOutput({tag, ":delay_size"}, delay_size, exp_size);
    checkOutput({tag, ":init_delay"}, init_delay, exp_init);
    checkOutput({tag, ":strobes"}, {instr_write, reg_write, reg_update}, 3'b000);
  endtask

  function automatic logic [31:0] bytesToWord(input int first, input int count);
    logic [31:0] v;
    v = 0;
    for (int i = 0; i < count; i++) v = v * 256 + 32'(payload[first + i]);
    return v;
  endfunction

  // send opcode + payload, drive the handshake, and update/check the model
  task automatic doCommand(input logic [7:0] op, input int ack_delay,
                           input int rst_len, input int max_stall);
    int hi;
    applyStimulus(op, $urandom_range(0, max_stall));
    foreach (payload[i]) applyStimulus(payload[i], $urandom_range(0, max_stall));
    case (op)
      8'h01: begin
        exp_block = payload[0];
        exp_instr = bytesToWord(1, 4);
        serviceAck(0, ack_delay, hi);
        checkOutput("instr_write_width", hi, ack_delay + 1);
        exp_cmds++;
      end
      8'h02, 8'h03: begin
        exp_block = payload[0];
        exp_regt  = 12'(payload[0]) * 16 + 12'(payload[1] % 16);
        exp_ctrl  = 16'(bytesToWord(2, 2));
        serviceAck((op == 8'h02) ? 1 : 2, ack_delay, hi);
        checkOutput("reg_strobe_width", hi, ack_delay + 1);
        exp_cmds++;
      end
      8'h04, 8'h05: begin
        if (op == 8'h04) begin
          exp_size = bytesToWord(0, 4);
          exp_init = bytesToWord(4, 4);
        end
        watchPulse((op == 8'h04) ? 0 : 1, hi);
        checkOutput("pulse_width", hi, 1);
        exp_cmds++;
      end
      8'h06: begin
        @(negedge clk);
        checkOutput("full_reset_pulse", full_reset, 1);
        resetting = 1'b1;
        repeat (rst_len) begin
          @(negedge clk);
          checkOutput("full_reset_low", full_reset, 0);
          checkOutput("reset_busy", busy, 1);
          checkOutput("reset_in_ready", in_ready, 0);
        end
        resetting = 1'b0;
        @(negedge clk);
        exp_cmds++;
      end
      default: exp_error = 1'b1;
    endcase
    checkAll("cmd");
  endtask

  initial begin
    int kind;
    int hi;
    logic [7:0] op;
    checks = 0; failures = 0;
    reset = 1'b1; in_byte = 8'd0; in_valid = 1'b0;
    instr_write_ack = 1'b0; reg_write_ack = 1'b0; resetting = 1'b0;
    exp_block = 0; exp_regt = 0; exp_instr = 0; exp_ctrl = 0;
    exp_size = 0; exp_init = 0; exp_cmds = 0; exp_error = 0;
    repeat (3) @(negedge clk);
    checkAll("reset");
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] directed: WRITE_REG with late ack");
    payload = '{8'h05, 8'h03, 8'h12, 8'h34};
    doCommand(8'h02, 3, 0, 0);
    checkOutput("wr_reg_target", reg_target, 12'h053);
    checkOutput("wr_ctrl_data", ctrl_data, 16'h1234);

    $display("[TB] directed: WRITE_INSTR with same-cycle ack");
    payload = '{8'h0A, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    doCommand(8'h01, 0, 0, 0);
    checkOutput("wi_instr_val", instr_val, 32'hDEADBEEF);

    $display("[TB] directed: ALLOC_DELAY then COMMIT");
    payload = '{8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00};
    doCommand(8'h04, 0, 0, 0);
    payload = {};
    doCommand(8'h05, 0, 0, 0);
    checkOutput("alloc_size", delay_size, 32'h1000);
    checkOutput("alloc_init", init_delay, 32'h400);

    $display("[TB] directed: unknown opcode then COMMIT");
    doCommand(8'h7F, 0, 0, 0);
    doCommand(8'h05, 0, 0, 0);
    checkOutput("error_sticky", error, 1);

    $display("[TB] directed: FULL_RESET with 10-cycle reset");
    doCommand(8'h06, 0, 10, 0);

    $display("[TB] randomized command frames");
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 3)) begin
        instr_write_ack = 1'($urandom);
        reg_write_ack   = 1'($urandom);
        @(negedge clk);
      end
      instr_write_ack = 1'b0;
      reg_write_ack   = 1'b0;
      kind = $urandom_range(1, 7);
      op = (kind == 7) ? 8'($urandom_range(7, 255)) : 8'(kind);
      payload = {};
      case (op)
        8'h01:        repeat (5) payload.push_back(8'($urandom));
        8'h02, 8'h03: repeat (4) payload.push_back(8'($urandom));
        8'h04:        repeat (8) payload.push_back(8'($urandom));
        default: ;
      endcase
      doCommand(op, $urandom_range(0, 5), $urandom_range(1, 8), 2);
    end

`ifdef CFG_TIMEOUT_EN
    $display("[TB] timeout: WRITE_REG without ack");
    payload = '{8'h21, 8'h0C, 8'hAB, 8'hCD};
    applyStimulus(8'h02, 0);
    foreach (payload[i]) applyStimulus(payload[i], 0);
    exp_block = 8'h21; exp_regt = 12'h21C; exp_ctrl = 16'hABCD;
    @(negedge clk);
    hi = 0;
    while (reg_write && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    checkOutput("timeout_width", hi, 16);
    exp_error = 1'b1;
    checkAll("timeout");
`endif

    $display("[TB] reset during payload");
    applyStimulus(8'h02, 0);
    applyStimulus(8'h05, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_block = 0; exp_regt = 0; exp_instr = 0; exp_ctrl = 0;
    exp_size = 0; exp_init = 0; exp_cmds = 0; exp_error = 0;
    checkAll("mid_reset");
    @(negedge clk);
    checkAll("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
